sw_ctrl: RTL

SW_CTRL -- requirements
Module: sw_ctrl

---
 rtl/sw_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/sw_ctrl.sv
// ---------------------------------------------------------------------------
// sw_ctrl -- job sequencer for a Smith-Waterman style systolic PE array.
//
// A job streams S_LEN query symbols into the S register array, then T_LEN
// database symbols into the T register array while the PE array computes,
// then flushes the array for DRAIN_LEN cycles and latches the array's
// running maximum as the job result.
//
// Optional feature (macro SW_CTRL_PERF_EN):
//   When defined, an extra output cycle_cnt counts the cycles of the job.
//   When undefined, that port and its logic do not exist.
//
// Parameters:
//   S_LEN      query symbols per job      (1..1023)
//   T_LEN      database symbols per job   (1..1023)
//   DRAIN_LEN  PE flush cycles after the last database symbol (1..1023)
//
// Ports:
//   clk         single clock, rising edge
//   reset       asynchronous, active-low reset
//   valid       host symbol strobe
//   data_s      query symbol from host
//   data_t      database symbol from host
//   max_in      running maximum score from the PE array
//   s_shift_en  shift strobe to the S register array
//   s_out       query symbol to the S register array
//   t_shift_en  shift strobe to the T register array
//   t_out       database symbol to the T register array
//   pe_enable   PE array compute enable
//   pe_clear    one-cycle PE score/max clear at the start of a job
//   busy        high while a job is in LOAD_S, RUN or DRAIN
//   finish      high for every DONE cycle; max holds the result
//   max         job result, latched when DRAIN ends
//   cycle_cnt   (SW_CTRL_PERF_EN only) job cycle counter, saturating
//   state_dbg   current FSM state encoding, for checkers and debug
// ---------------------------------------------------------------------------
module sw_ctrl #(
  parameter int S_LEN     = 128,
  parameter int T_LEN     = 512,
  parameter int DRAIN_LEN = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [1:0]  data_s,
  input  logic [1:0]  data_t,
  input  logic [11:0] max_in,
  output logic        s_shift_en,
  output logic [1:0]  s_out,
  output logic        t_shift_en,
  output logic [1:0]  t_out,
  output logic        pe_enable,
  output logic        pe_clear,
  output logic        busy,
  output logic        finish,
  output logic [11:0] max,
`ifdef SW_CTRL_PERF_EN
  output logic [15:0] cycle_cnt,
`endif
  output logic [2:0]  state_dbg
);

  // -------------------------------------------------------------------------
  // Host interface: there is no back-pressure. A symbol is consumed in every
  // cycle where valid is high and the FSM is in IDLE, LOAD_S, RUN or DONE.
  // In DRAIN valid is ignored and the symbol is dropped. In LOAD_S and RUN a
  // low valid is a stall: state and counter hold and no strobe fires.
  // -------------------------------------------------------------------------

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_S = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Terminal counts, truncated to the 10-bit counter width.
  localparam logic [9:0] S_LAST = S_LEN[9:0];
  localparam logic [9:0] T_LAST = T_LEN[9:0];
  localparam logic [9:0] D_LAST = DRAIN_LEN[9:0];

  state_t      state;
  logic [9:0]  count;
  logic [9:0]  count_inc;
  logic        start_state;   // IDLE or DONE: a valid here starts a new job

  assign count_inc   = count + 10'd1;
  assign start_state = (state == IDLE) || (state == DONE);

  // -------------------------------------------------------------------------
  // Combinational strobes. They follow valid in the same cycle so the
  // register arrays shift the symbol the host is presenting right now.
  // Every strobe is gated with reset so nothing fires while reset is low,
  // even though the host may still be driving valid.
  // -------------------------------------------------------------------------
  assign s_out      = data_s;
  assign t_out      = data_t;

  assign s_shift_en = reset && valid && (start_state || (state == LOAD_S));
  assign t_shift_en = reset && valid && (state == RUN);
  assign pe_clear   = reset && valid && start_state;

  // RUN computes only on cycles that bring a new database symbol; DRAIN
  // runs the array free to push the last symbols through the pipeline.
  assign pe_enable  = reset && (((state == RUN) && valid) || (state == DRAIN));

  // busy is decoded from the state register alone, so it behaves as a
  // registered output and is low in the cycle that first accepts a job.
  assign busy       = (state == LOAD_S) || (state == RUN) || (state == DRAIN);

  assign state_dbg  = state;

  // -------------------------------------------------------------------------
  // Main FSM. One 10-bit counter is shared by all phases: it counts query
  // symbols in LOAD_S, database symbols in RUN and flush cycles in DRAIN,
  // and is returned to zero at every phase boundary.
  //
  // The first query symbol is consumed in IDLE/DONE, so LOAD_S starts with
  // the counter already at 1. With S_LEN == 1 that first symbol completes
  // the query, so the FSM goes straight to RUN with the counter at 0.
  //
  // max is cleared at the start of a job (the same cycle pe_clear clears
  // the PE array) and loaded from max_in on the DRAIN->DONE edge, so a
  // reset or a new job can never expose a stale or partial result.
  // finish is set on entry to DONE and cleared on leaving it.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      count  <= '0;
      max    <= '0;
      finish <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (valid) begin
            finish <= 1'b0;
            max    <= '0;
            if (S_LEN == 1) begin
              count <= '0;
              state <= RUN;
            end else begin
              count <= 10'd1;
              state <= LOAD_S;
            end
          end
        end

        LOAD_S: begin
          if (valid) begin
            if (count_inc == S_LAST) begin
              count <= '0;
              state <= RUN;
            end else begin
              count <= count_inc;
            end
          end
        end

        RUN: begin
          if (valid) begin
            if (count_inc == T_LAST) begin
              count <= '0;
              state <= DRAIN;
            end else begin
              count <= count_inc;
            end
          end
        end

        DRAIN: begin
          // Counts every cycle regardless of valid; the last flush cycle is
          // the one where the incremented count reaches DRAIN_LEN.
          if (count_inc == D_LAST) begin
            count  <= '0;
            state  <= DONE;
            max    <= max_in;
            finish <= 1'b1;
          end else begin
            count <= count_inc;
          end
        end

        default: begin
          state  <= IDLE;
          count  <= '0;
          finish <= 1'b0;
        end
      endcase
    end
  end

`ifdef SW_CTRL_PERF_EN
  // -------------------------------------------------------------------------
  // Job cycle counter. The cycle that starts a job (pe_clear) already
  // consumes the first query symbol, so the count restarts at 1 rather
  // than 0; every following busy cycle adds one. Outside a job (IDLE,
  // DONE) the value holds so the host can read it alongside the result.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= '0;
    end else if (pe_clear) begin
      cycle_cnt <= 16'd1;
    end else if (busy && (cycle_cnt != 16'hFFFF)) begin
      cycle_cnt <= cycle_cnt + 16'd1;
    end
  end
`endif

endmodule
